// File: rtl/alu16_pkg.sv
// Shared types and constants for the sign-magnitude ALU result path.
// Includes the leading-zero blank mask helper used by the BCD stage.
package alu16_pkg;

  localparam int MAG_W       = 15;
  localparam int DIGITS      = 5;
  localparam int BCD_W       = 4 * DIGITS;
  localparam int SM_SIGN_BIT = 15;
  localparam int CNT_W       = 4;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAG_W - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Units digit is never blanked so zero still shows as a single "0".
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] b);
    logic              run;
    logic [DIGITS-1:0] m;
    run = 1'b1;
    m   = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run  = run & (b[4*i +: 4] == 4'd0);
      m[i] = run;
    end
    return m;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] din_i,
  output logic [3:0] dout_o
);

  assign dout_o = (din_i >= 4'd5) ? din_i + 4'd3 : din_i;

endmodule

// File: rtl/alu_result_bcd.sv
// Converts one sign-magnitude ALU result to packed BCD for the display; result
// appears MAG_W clocks after acceptance and is held until out_ready.
module alu_result_bcd
  import alu16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SM_SIGN_BIT:0] in_data,
  input  logic                 in_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BCD_W-1:0]     bcd,
  output logic                 neg,
  output logic                 ovf,
  output logic [DIGITS-1:0]    blank
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   bcdw_q, bcdw_d;
  logic               sgn_q, sgn_d;
  logic               ovfw_q, ovfw_d;

  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic [DIGITS-1:0]  blank_q, blank_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;
  logic               adj_msb_unused;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din_i  (bcdw_q[4*g +: 4]),
      .dout_o (adj[4*g +: 4])
    );
  end

  // The top digit never exceeds 3 for a 15-bit magnitude, so its carry-out is dropped.
  assign adj_msb_unused = adj[BCD_W-1];
  assign shifted        = {adj[BCD_W-2:0], mag_q[MAG_W-1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    bcdw_d  = bcdw_q;
    sgn_d   = sgn_q;
    ovfw_d  = ovfw_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    blank_d = blank_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_d   = in_data[MAG_W-1:0];
          sgn_d   = in_data[SM_SIGN_BIT];
          ovfw_d  = in_ovf;
          bcdw_d  = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcdw_d = shifted;
        mag_d  = {mag_q[MAG_W-2:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Publish only complete conversions; negative zero shows as +0.
          bcd_d   = shifted;
          neg_d   = sgn_q & (shifted != '0);
          ovf_d   = ovfw_q;
          blank_d = blank_mask(shifted);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      bcdw_q  <= '0;
      sgn_q   <= 1'b0;
      ovfw_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      blank_q <= BLANK_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      bcdw_q  <= bcdw_d;
      sgn_q   <= sgn_d;
      ovfw_q  <= ovfw_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      blank_q <= blank_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd       = bcd_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign blank     = blank_q;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Directed vector bench for alu_result_bcd: table of conversions plus
// hand sequences for backpressure, back-to-back transfers and mid-conversion reset.
module tb_alu_result_bcd;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] bcd;
  logic        neg;
  logic        ovf;
  logic [4:0]  blank;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [15:0] din;
    logic        ovf_in;
    logic [19:0] exp_bcd;
    logic        exp_neg;
    logic        exp_ovf;
    logic [4:0]  exp_blank;
  } vec_t;

  vec_t vecs [10];

  alu_result_bcd dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ovf    (in_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .neg       (neg),
    .ovf       (ovf),
    .blank     (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_ready: in_ready still %b after %0d clocks", in_ready, n);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    wait_ready();
    in_data  = v.din;
    in_ovf   = v.ovf_in;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk($sformatf("v%0d latency", idx), lat, 15);
    chk($sformatf("v%0d bcd", idx), bcd, v.exp_bcd);
    chk($sformatf("v%0d neg", idx), neg, v.exp_neg);
    chk($sformatf("v%0d ovf", idx), ovf, v.exp_ovf);
    chk($sformatf("v%0d blank", idx), blank, v.exp_blank);
  endtask

  initial begin
    int   lat;
    int   xfer2;
    int   done2;
    logic rdy_prev;
    logic stable;
    logic seen;

    n_vec = 0;
    n_bad = 0;

    vecs[0] = '{16'h7FFF, 1'b0, 20'h32767, 1'b0, 1'b0, 5'b00000};
    vecs[1] = '{16'h0000, 1'b0, 20'h00000, 1'b0, 1'b0, 5'b11110};
    vecs[2] = '{16'h8005, 1'b0, 20'h00005, 1'b1, 1'b0, 5'b11110};
    vecs[3] = '{16'h8000, 1'b0, 20'h00000, 1'b0, 1'b0, 5'b11110};
    vecs[4] = '{16'h04D2, 1'b1, 20'h01234, 1'b0, 1'b1, 5'b10000};
    vecs[5] = '{16'h0064, 1'b0, 20'h00100, 1'b0, 1'b0, 5'b11000};
    vecs[6] = '{16'h8309, 1'b0, 20'h00777, 1'b1, 1'b0, 5'b11000};
    vecs[7] = '{16'h270F, 1'b1, 20'h09999, 1'b0, 1'b1, 5'b10000};
    vecs[8] = '{16'h2710, 1'b0, 20'h10000, 1'b0, 1'b0, 5'b00000};
    vecs[9] = '{16'hFFFF, 1'b1, 20'h32767, 1'b1, 1'b1, 5'b00000};

    // Reset with in_valid asserted: the request must be discarded.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0042;
    in_ovf    = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst bcd", bcd, 20'h00000);
    chk("rst neg", neg, 0);
    chk("rst ovf", ovf, 0);
    chk("rst blank", blank, 5'b11110);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

    // Backpressure: outputs and DONE hold while out_ready is low; in_valid held is ignored.
    wait_ready();
    out_ready = 1'b0;
    in_data   = 16'h04D2;
    in_ovf    = 1'b1;
    in_valid  = 1'b1;
    tick();
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp latency", lat, 15);
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("bp out_valid c%0d", j), out_valid, 1);
      chk($sformatf("bp bcd c%0d", j), bcd, 20'h01234);
      chk($sformatf("bp in_ready c%0d", j), in_ready, 0);
    end
    chk("bp ovf", ovf, 1);
    chk("bp blank", blank, 5'b10000);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    chk("bp release in_ready", in_ready, 1);
    chk("bp release out_valid", out_valid, 0);
    chk("bp hold bcd in idle", bcd, 20'h01234);
    repeat (3) tick();
    chk("bp no second capture", out_valid, 0);

    // Back-to-back with in_valid held: 15 shifts, one DONE cycle and one IDLE
    // bubble put the second transfer edge 17 edges after the first.
    wait_ready();
    in_data   = 16'h0064;
    in_ovf    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    xfer2  = -1;
    done2  = -1;
    stable = 1'b1;
    for (int k = 0; k < 60 && done2 < 0; k++) begin
      rdy_prev = in_ready;
      tick();
      if (k == 0) begin
        in_data = 16'h8309;
      end else if (rdy_prev && in_valid && xfer2 < 0) begin
        xfer2    = k;
        in_valid = 1'b0;
      end
      if (k == 15) begin
        chk("b2b first out_valid", out_valid, 1);
        chk("b2b first neg", neg, 0);
      end
      if (k >= 15 && out_valid && xfer2 >= 0) begin
        done2 = k;
      end else if (k >= 15 && bcd !== 20'h00100) begin
        stable = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b second transfer edge", xfer2, 17);
    chk("b2b second latency", done2 - xfer2, 15);
    chk("b2b first result held", stable, 1);
    chk("b2b second bcd", bcd, 20'h00777);
    chk("b2b second neg", neg, 1);

    // Reset during the 7th SHIFT cycle loses the conversion.
    wait_ready();
    in_data  = 16'h1234;
    in_ovf   = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("mid rst busy", in_ready, 0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0009;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mid rst in_ready", in_ready, 1);
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst bcd", bcd, 20'h00000);
    chk("mid rst neg", neg, 0);
    chk("mid rst ovf", ovf, 0);
    chk("mid rst blank", blank, 5'b11110);
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      seen = seen | out_valid;
    end
    chk("mid rst no out_valid", seen, 0);
    run_vec('{16'h0001, 1'b0, 20'h00001, 1'b0, 1'b0, 5'b11110}, 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
